// File: rtl/framebuffer_dual.sv
// Double-buffered 16-bit framebuffer: GPU pixel writes land in the back buffer,
// a raster-order scanout stream reads the front buffer, and swaps happen only at frame wrap.
module framebuffer_dual #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(FB_WIDTH):0]     fb_x,
  input  logic [$clog2(FB_HEIGHT):0]    fb_y,
  input  logic [15:0]                   fb_color,
  input  logic                          fb_write,
  input  logic                          swap_req,
  output logic                          swap_pending,
  output logic                          swap_done,
  output logic                          front_sel,
  output logic [15:0]                   out_color,
  output logic [$clog2(FB_WIDTH):0]     out_x,
  output logic [$clog2(FB_HEIGHT):0]    out_y,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int XW    = $clog2(FB_WIDTH) + 1;
  localparam int YW    = $clog2(FB_HEIGHT) + 1;
  localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [XW-1:0] X_LIM  = XW'(FB_WIDTH);
  localparam logic [YW-1:0] Y_LIM  = YW'(FB_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FB_HEIGHT - 1);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
  } meta_t;

  typedef struct packed {
    logic [15:0] color;
    meta_t       meta;
  } pix_t;

  function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(FB_WIDTH) + AW'(x);
  endfunction

  logic [15:0]   mem0 [DEPTH];
  logic [15:0]   mem1 [DEPTH];
  logic [15:0]   q0, q1;

  logic [XW-1:0] rx;
  logic [YW-1:0] ry;
  logic          rd_valid;
  logic          rd_buf;
  meta_t         rd_meta;

  pix_t          fifo_q [2];
  logic          head;
  logic [1:0]    cnt;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;
  logic          last_pix;
  logic          do_swap;
  logic          tail;
  logic [15:0]   rd_color;
  pix_t          head_pix;

  assign wr_en    = fb_write && (fb_x < X_LIM) && (fb_y < Y_LIM);
  assign wr_addr  = addr_of(fb_x, fb_y);
  assign rd_addr  = addr_of(rx, ry);

  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  // Occupancy counts the read already in flight so the two skid slots can never overflow.
  assign occ       = cnt + 2'(rd_valid);
  assign issue     = (occ < 2'd2) || pop;
  assign last_pix  = (rx == X_LAST) && (ry == Y_LAST);
  assign do_swap   = issue && last_pix && (swap_pending || swap_req);

  assign tail      = head ^ cnt[0];
  assign rd_color  = rd_buf ? q1 : q0;
  assign head_pix  = fifo_q[head];

  assign out_color = head_pix.color;
  assign out_x     = head_pix.meta.x;
  assign out_y     = head_pix.meta.y;
  assign out_sof   = head_pix.meta.sof;
  assign out_eol   = head_pix.meta.eol;

  // NOTE: pixel RAMs have no reset so they map onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && front_sel)  mem0[wr_addr] <= fb_color;
    if (wr_en && !front_sel) mem1[wr_addr] <= fb_color;
    q0 <= mem0[rd_addr];
    q1 <= mem1[rd_addr];
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx           <= '0;
      ry           <= '0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      rd_valid     <= 1'b0;
      rd_buf       <= 1'b0;
      rd_meta      <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      head         <= 1'b0;
      cnt          <= 2'd0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end

      rd_valid <= issue;
      if (issue) begin
        rd_buf      <= front_sel;
        rd_meta.x   <= rx;
        rd_meta.y   <= ry;
        rd_meta.sof <= (rx == '0) && (ry == '0);
        rd_meta.eol <= (rx == X_LAST);
        if (rx == X_LAST) begin
          rx <= '0;
          ry <= (ry == Y_LAST) ? '0 : ry + YW'(1);
        end else begin
          rx <= rx + XW'(1);
        end
      end

      // A push only happens with at most one entry held, so tail is always a free slot.
      if (rd_valid) fifo_q[tail] <= {rd_color, rd_meta};
      if (pop)      head <= ~head;
      cnt <= cnt + 2'(rd_valid) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_framebuffer_dual.sv
// Directed bench for framebuffer_dual on a 12x6 frame: scanout order and markers,
// stall stability, swap timing, out-of-range write drop, and reset behaviour.
module tb_framebuffer_dual;

  localparam int W = 12;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  fb_x;
  logic [3:0]  fb_y;
  logic [15:0] fb_color;
  logic        fb_write;
  logic        swap_req;
  logic        swap_pending;
  logic        swap_done;
  logic        front_sel;
  logic [15:0] out_color;
  logic [4:0]  out_x;
  logic [3:0]  out_y;
  logic        out_sof;
  logic        out_eol;
  logic        out_valid;
  logic        out_ready;

  framebuffer_dual #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk(clk), .reset(reset),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
    .front_sel(front_sel),
    .out_color(out_color), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eol(out_eol),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;

  // Reference picture of both buffers; only locations the bench wrote are compared.
  logic [15:0] model [2][N];
  bit          known [2][N];
  bit          model_fs;
  bit          frame_buf;
  bit          toggle_due;
  int          done_count;
  int          ex, ey;
  bit          stalled_prev;
  logic [15:0] held_color;
  logic [4:0]  held_x;
  logic [3:0]  held_y;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: called at a negedge with this cycle's inputs already driven.
  task automatic cycle();
    if (swap_done) begin
      done_count++;
      model_fs   = ~model_fs;
      toggle_due = 1'b1;
    end
    if (fb_write && int'(fb_x) < W && int'(fb_y) < H) begin
      model[!model_fs][int'(fb_y) * W + int'(fb_x)] = fb_color;
      known[!model_fs][int'(fb_y) * W + int'(fb_x)] = 1'b1;
    end
    if (stalled_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_color", out_color, held_color);
      check("hold_x", out_x, held_x);
      check("hold_y", out_y, held_y);
    end
    if (out_valid && out_ready) begin
      if (ex == 0 && ey == 0 && toggle_due) begin
        frame_buf  = ~frame_buf;
        toggle_due = 1'b0;
      end
      check("pix_x", out_x, ex);
      check("pix_y", out_y, ey);
      check("pix_sof", out_sof, (ex == 0 && ey == 0));
      check("pix_eol", out_eol, (ex == W - 1));
      if (known[frame_buf][ey * W + ex])
        check("pix_color", out_color, model[frame_buf][ey * W + ex]);
      if (ex == W - 1) begin
        ex = 0;
        ey = (ey == H - 1) ? 0 : ey + 1;
      end else begin
        ex++;
      end
    end
    stalled_prev = out_valid && !out_ready;
    held_color   = out_color;
    held_x       = out_x;
    held_y       = out_y;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_pix(input int x, input int y);
    int n = 0;
    while (!(out_valid && int'(out_x) == x && int'(out_y) == y) && n < 400) begin
      cycle();
      n++;
    end
    check("wait_pix_in_time", (n < 400), 1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fb_write  = 1'b0;
    swap_req  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_pending", swap_pending, 0);
    check("rst_done", swap_done, 0);
    check("rst_front", front_sel, 0);
    check("rst_color", out_color, 0);
    check("rst_x", out_x, 0);
    check("rst_y", out_y, 0);
    check("rst_sof", out_sof, 0);
    check("rst_eol", out_eol, 0);
    ex = 0; ey = 0;
    frame_buf = 1'b0; toggle_due = 1'b0; model_fs = 1'b0; stalled_prev = 1'b0;
    done_count = 0;
    reset = 1'b0;
    cycle();
    check("lat_cycle1_valid", out_valid, 0);
    cycle();
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_first_x", out_x, 0);
    check("lat_first_y", out_y, 0);
    check("lat_first_sof", out_sof, 1);
  endtask

  int oor_x [5] = '{12, 12, 0, 31, 5};
  int oor_y [5] = '{0, 1, 6, 2, 15};

  initial begin
    reset = 1'b1; fb_x = '0; fb_y = '0; fb_color = '0; fb_write = 1'b0;
    swap_req = 1'b0; out_ready = 1'b1;

    // Reset, latency, and coordinate/marker sequence across a wrap.
    do_reset();
    run(N + 10);

    // Fill buffer 1, attempt out-of-range writes, swap, then scan buffer 1.
    for (int a = 0; a < N; a++) begin
      fb_write = 1'b1; fb_x = 5'(a % W); fb_y = 4'(a / W); fb_color = 16'h1000 + 16'(a);
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      fb_write = 1'b1; fb_x = 5'(oor_x[i]); fb_y = 4'(oor_y[i]); fb_color = 16'hFFFF;
      cycle();
    end
    fb_write = 1'b0;
    done_count = 0;
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
    run(3 * N);
    check("swap1_done_count", done_count, 1);
    check("swap1_front", front_sel, 1);

    // Fill buffer 0 with y*W+x, three requests inside one frame give one swap.
    for (int a = 0; a < N; a++) begin
      fb_write = 1'b1; fb_x = 5'(a % W); fb_y = 4'(a / W); fb_color = 16'(a);
      cycle();
    end
    fb_write = 1'b0;
    wait_pix(0, 1);
    done_count = 0;
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
    check("multi_req_pending", swap_pending, 1);
    run(3);
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
    run(3);
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
    run(2 * N);
    check("multi_req_done_count", done_count, 1);
    check("multi_req_front", front_sel, 0);

    // Random back-pressure with a single pixel write and a swap into buffer 1.
    fb_write = 1'b1; fb_x = 5'd10; fb_y = 4'd5; fb_color = 16'hABCD;
    out_ready = 1'($urandom_range(0, 1));
    cycle();
    fb_write = 1'b0;
    done_count = 0;
    swap_req = 1'b1; out_ready = 1'($urandom_range(0, 1)); cycle(); swap_req = 1'b0;
    for (int i = 0; i < 5 * N; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    out_ready = 1'b1;
    check("stall_done_count", done_count, 1);
    check("stall_front", front_sel, 1);
    check("abcd_in_model", model[1][5 * W + 10], 16'hABCD);

    // Request in the very cycle the last pixel read is issued.
    run(6);
    wait_pix(W - 3, H - 1);
    done_count = 0;
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
    check("wrap_req_done_now", swap_done, 1);
    check("wrap_req_pending", swap_pending, 0);
    check("wrap_req_front", front_sel, 0);
    run(N);
    check("wrap_req_done_count", done_count, 1);

    // Reset mid-frame with a swap pending; RAM contents must survive.
    wait_pix(6, 3);
    swap_req = 1'b1; cycle(); swap_req = 1'b0;
    check("mid_pending_set", swap_pending, 1);
    do_reset();
    run(N + 5);
    check("post_reset_done_count", done_count, 0);
    check("post_reset_front", front_sel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
